// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// No timing of its own; backpressure n/a.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Low bit of lane `lane` in a flattened bus of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read lane: zero-register check, port1/port0 bypass mux, array read.
// Latency 0 (combinational); backpressure none, forced to 0 while disabled.
import regfile_pkg::*;

module regfile_rd_port #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic [DW-1:0] arr_dat,
    output logic [DW-1:0] dat
);

    always_comb begin
        dat = arr_dat;
        if (!en) begin
            dat = '0;
        end else if (ZERO_REG != 0 && addr == '0) begin
            dat = '0;
        end else if (BYPASS != 0 && we1 && wa1 == addr) begin
            dat = wd1;
        end else if (BYPASS != 0 && we0 && wa0 == addr) begin
            dat = wd0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR read lanes, two prioritised write ports, post-reset clear sweep.
// Reads 0 cycles, writes 1 edge; backpressure: writes ignored until ready (DEPTH edges after reset).
import regfile_pkg::*;

module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    output logic             ready
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] mem [DEPTH];
    state_e        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic          wr0, wr1;
    logic          rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == AW'(DEPTH - 1)) state_nxt = RUN;
            end
            RUN:   state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ready = (state == RUN);
        rd_en = ready && !rst;
    end

    // Port 1 wins an address clash; port 0's write is suppressed outright.
    always_comb begin
        wr1 = we1 && !(ZERO_REG != 0 && wa1 == '0);
        wr0 = we0 && !(ZERO_REG != 0 && wa0 == '0) && !(we1 && wa1 == wa0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else begin
                if (wr0) mem[wa0] <= wd0;
                if (wr1) mem[wa1] <= wd1;
            end
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = ra[lane_lo(g, AW) +: AW];

        regfile_rd_port #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .en      (rd_en),
            .addr    (addr),
            .we0     (we0),
            .wa0     (wa0),
            .wd0     (wd0),
            .we1     (we1),
            .wa1     (wa1),
            .wd1     (wd1),
            .arr_dat (mem[addr]),
            .dat     (rd[lane_lo(g, DW) +: DW])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass/no-bypass instances at 32x32x3, plus a 16x8x4 instance vs a model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instances A (BYPASS=1) and B (BYPASS=0) share all inputs.
    logic        rst_ab;
    logic [14:0] ra_ab;
    logic        we0_ab, we1_ab;
    logic [4:0]  wa0_ab, wa1_ab;
    logic [31:0] wd0_ab, wd1_ab;
    logic [95:0] rd_a, rd_b;
    logic        ready_a, ready_b;

    logic        rst_c;
    logic [11:0] ra_c;
    logic        we0_c, we1_c;
    logic [2:0]  wa0_c, wa1_c;
    logic [15:0] wd0_c, wd1_c;
    logic [63:0] rd_c;
    logic        ready_c;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    regfile_mp #(.DW(32), .AW(5), .NR(3), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst_ab), .ra(ra_ab), .rd(rd_a),
        .we0(we0_ab), .wa0(wa0_ab), .wd0(wd0_ab),
        .we1(we1_ab), .wa1(wa1_ab), .wd1(wd1_ab), .ready(ready_a));

    regfile_mp #(.DW(32), .AW(5), .NR(3), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst_ab), .ra(ra_ab), .rd(rd_b),
        .we0(we0_ab), .wa0(wa0_ab), .wd0(wd0_ab),
        .we1(we1_ab), .wa1(wa1_ab), .wd1(wd1_ab), .ready(ready_b));

    regfile_mp #(.DW(16), .AW(3), .NR(4), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst_c), .ra(ra_c), .rd(rd_c),
        .we0(we0_c), .wa0(wa0_c), .wd0(wd0_c),
        .we1(we1_c), .wa1(wa1_c), .wd1(wd1_c), .ready(ready_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] mdl [8];
    logic [15:0] exp_c;
    logic [2:0]  a_c;
    bit          early;
    bit          nz;

    initial begin
        rst_ab = 1'b1; ra_ab = '0; we0_ab = 1'b0; we1_ab = 1'b0;
        wa0_ab = '0; wa1_ab = '0; wd0_ab = '0; wd1_ab = '0;
        rst_c = 1'b1; ra_c = '0; we0_c = 1'b0; we1_c = 1'b0;
        wa0_c = '0; wa1_c = '0; wd0_c = '0; wd1_c = '0;

        // Reset state
        tick(); tick();
        ra_ab = {5'd2, 5'd1, 5'd5};
        #1;
        chk("reset_ready_a", 128'(ready_a), 128'(0));
        chk("reset_ready_b", 128'(ready_b), 128'(0));
        chk("reset_rd_a", 128'(rd_a), 128'(0));

        // Power-up sweep
        rst_ab = 1'b0;
        for (int i = 0; i < 40 && !ready_a; i++) tick();
        chk("powerup_ready", 128'(ready_a), 128'(1));

        // Reset sweep: m[5]=DEAD then one-cycle rst
        we0_ab = 1'b1; wa0_ab = 5'd5; wd0_ab = 32'h0000_DEAD;
        tick();
        we0_ab = 1'b0;
        ra_ab = {5'd0, 5'd0, 5'd5};
        #1;
        chk("pre_sweep_m5", 128'(rd_b[31:0]), 128'(32'hDEAD));
        rst_ab = 1'b1;
        tick();
        rst_ab = 1'b0;
        #1;
        chk("sweep_ready_drop", 128'(ready_a), 128'(0));
        early = 1'b0; nz = 1'b0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (ready_a || ready_b) early = 1'b1;
            if (rd_a[31:0] != 0 || rd_b[31:0] != 0) nz = 1'b1;
        end
        chk("sweep_ready_low_31", 128'(early), 128'(0));
        chk("sweep_rd_zero", 128'(nz), 128'(0));
        tick();
        chk("sweep_ready_at_32", 128'(ready_a), 128'(1));
        chk("sweep_ready_at_32_b", 128'(ready_b), 128'(1));
        chk("sweep_m5_cleared", 128'(rd_a[31:0]), 128'(0));

        // Write conflict on address 7
        ra_ab = {5'd0, 5'd7, 5'd0};
        we0_ab = 1'b1; wa0_ab = 5'd7; wd0_ab = 32'h1111;
        we1_ab = 1'b1; wa1_ab = 5'd7; wd1_ab = 32'h2222;
        #1;
        chk("conflict_bypass_a", 128'(rd_a[63:32]), 128'(32'h2222));
        chk("conflict_nobyp_b", 128'(rd_b[63:32]), 128'(0));
        tick();
        we0_ab = 1'b0; we1_ab = 1'b0;
        #1;
        chk("conflict_store_a", 128'(rd_a[63:32]), 128'(32'h2222));
        chk("conflict_store_b", 128'(rd_b[63:32]), 128'(32'h2222));

        // Bypass on lane 2
        ra_ab = {5'd3, 5'd7, 5'd0};
        we0_ab = 1'b1; wa0_ab = 5'd3; wd0_ab = 32'hABCD;
        #1;
        chk("bypass_same_a", 128'(rd_a[95:64]), 128'(32'hABCD));
        chk("bypass_old_b", 128'(rd_b[95:64]), 128'(0));
        tick();
        we0_ab = 1'b0;
        #1;
        chk("bypass_next_a", 128'(rd_a[95:64]), 128'(32'hABCD));
        chk("bypass_next_b", 128'(rd_b[95:64]), 128'(32'hABCD));
        ra_ab = {5'd5, 5'd7, 5'd3};
        #1;
        chk("multi_lane_a", 128'(rd_a), 128'({32'h0, 32'h2222, 32'hABCD}));

        // Register zero with port 1 write
        ra_ab = '0;
        we1_ab = 1'b1; wa1_ab = 5'd0; wd1_ab = 32'hFFFF_FFFF;
        #1;
        chk("zero_same_a", 128'(rd_a), 128'(0));
        chk("zero_same_b", 128'(rd_b), 128'(0));
        tick();
        we1_ab = 1'b0;
        #1;
        chk("zero_after_a", 128'(rd_a), 128'(0));
        chk("zero_after_b", 128'(rd_b), 128'(0));

        // Mid-sweep reset at ptr 10, we0 pulses during the restarted sweep
        rst_ab = 1'b1;
        tick();
        rst_ab = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_ready_low", 128'(ready_a), 128'(0));
        rst_ab = 1'b1;
        tick();
        rst_ab = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 31; i++) begin
            we0_ab = (i >= 20 && i < 23);
            wa0_ab = 5'd2; wd0_ab = 32'hBEEF;
            tick();
            if (ready_a) early = 1'b1;
        end
        we0_ab = 1'b0;
        chk("mid_no_ready_at_22", 128'(early), 128'(0));
        tick();
        chk("mid_ready_at_32", 128'(ready_a), 128'(1));
        ra_ab = {5'd2, 5'd7, 5'd2};
        #1;
        chk("mid_we0_no_trace", 128'(rd_a), 128'(0));

        // 16x8x4 instance: sweep then random traffic vs model
        tick();
        rst_c = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (ready_c) early = 1'b1;
        end
        chk("c_ready_low_7", 128'(early), 128'(0));
        tick();
        chk("c_ready_at_8", 128'(ready_c), 128'(1));
        for (int k = 0; k < 8; k++) mdl[k] = '0;
        for (int n = 0; n < 40; n++) begin
            we0_c = 1'($urandom_range(0, 1));
            we1_c = 1'($urandom_range(0, 1));
            wa0_c = 3'($urandom_range(0, 7));
            wa1_c = 3'($urandom_range(0, 7));
            wd0_c = 16'($urandom);
            wd1_c = 16'($urandom);
            ra_c  = 12'($urandom);
            #1;
            for (int l = 0; l < 4; l++) begin
                a_c = ra_c[l*3 +: 3];
                exp_c = mdl[a_c];
                if (we0_c && wa0_c == a_c) exp_c = wd0_c;
                if (we1_c && wa1_c == a_c) exp_c = wd1_c;
                if (a_c == 3'd0) exp_c = '0;
                chk($sformatf("c_rand_%0d_lane%0d", n, l), 128'(rd_c[l*16 +: 16]), 128'(exp_c));
            end
            if (we0_c && wa0_c != 3'd0) mdl[wa0_c] = wd0_c;
            if (we1_c && wa1_c != 3'd0) mdl[wa1_c] = wd1_c;
            tick();
        end
        we0_c = 1'b0; we1_c = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the multi-cycle CPU datapath, and the next generation of the 32×32 three-read/one-write register file. Width, depth and read-port count are parameters. Two write ports are arbitrated by fixed priority, same-cycle write-to-read bypass is optional, and a post-reset clear sweep zeroes the array one entry per cycle, with a `ready` flag the control FSM must wait on.

## Interface

Parameters:
- `DW`, 32: data width in bits.
- `AW`, 5: address width; depth is `1<<AW`.
- `NR`, 3: number of read ports (≥1).
- `ZERO_REG`, 1: when 1, entry 0 reads as 0 and ignores writes.
- `BYPASS`, 1: when 1, a read returns the write data of a same-cycle write to the same address.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ra` in NR*AW: read addresses; port i occupies `[i*AW +: AW]`.
- `rd` out NR*DW: read data; port i occupies `[i*DW +: DW]`.
- `we0` in 1: write enable, port 0.
- `wa0` in AW: write address, port 0.
- `wd0` in DW: write data, port 0.
- `we1` in 1: write enable, port 1; has priority over port 0.
- `wa1` in AW: write address, port 1.
- `wd1` in DW: write data, port 1.
- `ready` out 1: array cleared; writes are accepted.

## Operation

- Two states: CLEAR and RUN.
- `rst`=1 at a rising edge:
  - state ← CLEAR, sweep pointer ← 0.
  - Entry contents are not touched on that edge.
- CLEAR:
  - Each edge with `rst`=0 writes 0 to `m[ptr]`, then `ptr` ← `ptr+1`.
  - After writing entry `DEPTH-1`, state ← RUN.
  - `we0`/`we1` are ignored.
  - All `rd` lanes output 0.
- RUN, write rules:
  - `weK`=1 writes `wdK` to `m[waK]` on the rising edge.
  - `we0` and `we1` to the same address in one cycle: only `wd1` is stored.
  - `ZERO_REG`=1: writes to address 0 are dropped.
- RUN, read rules (combinational, per port, in priority order):
  1. `ZERO_REG` and `ra_i`=0 → 0.
  2. `BYPASS`, `we1`, `wa1`=`ra_i` → `wd1`.
  3. `BYPASS`, `we0`, `wa0`=`ra_i` → `wd0`.
  4. Otherwise → `m[ra_i]`.
- `BYPASS`=0: reads return the pre-edge contents; new data becomes visible the cycle after the write.
- `rst` reasserted mid-sweep or in RUN: the sweep restarts from entry 0 and `ready` drops on that edge.

## Timing

- Reset values:
  - `ready`=0.
  - State CLEAR, `ptr`=0.
  - `rd`=0 on all lanes during reset and throughout CLEAR.
- Clear sweep: takes exactly `DEPTH` edges after `rst` deasserts. `ready` rises after the edge that writes entry `DEPTH-1` (32 cycles for `AW`=5).
- Read latency: 0 cycles (combinational from `ra`, `we*`, `wa*`, `wd*` and array state).
- Write latency: 1 edge.
- `ready` is registered and changes only on clock edges.

## Structure

- Package `regfile_pkg`:
  - state enum `{CLEAR, RUN}`.
  - `DEPTH` derived as `1<<AW`.
  - Lane-slice helper functions for the flattened `ra`/`rd` buses.
- Sub-module `regfile_rd_port`:
  - One read lane: zero check, two-level bypass mux, array read.
  - Instantiated `NR` times in a generate loop.
- Top level holds the array, the write-priority logic, and the clear FSM with its pointer.

## Test plan

- Reset sweep:
  - Write `m[5]`=0xDEAD in RUN, pulse `rst` for one cycle.
  - `ready`=0 for exactly 32 cycles, then 1.
  - `rd` on port 0 with `ra`=5 reads 0 throughout and after.
- Write conflict:
  - `we0`=`we1`=1, `wa0`=`wa1`=7, `wd0`=0x1111, `wd1`=0x2222.
  - Next cycle `m[7]` reads 0x2222.
- Bypass:
  - `BYPASS`=1, `we0`=1, `wa0`=3, `wd0`=0xABCD, `ra` lane 2 = 3.
  - `rd` lane 2 = 0xABCD in the same cycle.
  - Repeat with `BYPASS`=0: old value shown that cycle, 0xABCD the next.
- Register zero:
  - `ZERO_REG`=1, write 0xFFFF_FFFF to address 0 on port 1 with bypass on.
  - All lanes reading address 0 show 0 in that cycle and after.
- Mid-sweep reset:
  - Assert `rst` at sweep pointer 10, release.
  - `ready` rises 32 cycles after release, not 22.
  - `we0` pulses during the sweep leave no trace.
- Parameter sweep:
  - `DW`=16, `AW`=3, `NR`=4.
  - Random writes and reads checked against a reference model.
  - `ready` after 8 cycles.
